// File: rtl/player_bitmap_animator.sv
// Tank pixel generator: tread animation, 4-way rotation, player recolour, hit blink.
// Latency: 2 clk from offset/insideRect to drawingRequest/RGBout.
// No backpressure: one pixel is accepted every clock.
module player_bitmap_animator #(
  parameter int         OBJECT_SIZE   = 32,
  parameter int         ANIM_FRAMES   = 4,
  parameter int         INVULN_FRAMES = 120,
  parameter int         BLINK_PERIOD  = 8,
  parameter logic [7:0] KEY_COLOR     = 8'hE0,
  parameter logic [7:0] P0_COLOR      = 8'h1C,
  parameter logic [7:0] P1_COLOR      = 8'h5B,
  parameter logic [7:0] TRANSPARENT   = 8'hFF,
  // Up-facing image, 2 tread frames x OBJECT_SIZE rows x OBJECT_SIZE px x 8 bit.
  // Pixel (frame f, row r, col c) lives at bit offset ((f*SIZE + r)*SIZE + c)*8.
  // Supplied as a constant so the ROM needs no load-time file access.
  parameter logic [2*OBJECT_SIZE*OBJECT_SIZE*8-1:0] BITMAP_IMAGE =
    {(2*OBJECT_SIZE*OBJECT_SIZE){8'hFF}}
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        insideRect,
  input  logic [1:0]  direction,
  input  logic        moving,
  input  logic        hit,
  input  logic        player_index,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic        invulnerable
);

  localparam int AW  = $clog2(OBJECT_SIZE);
  localparam int RAW = 2 * AW + 1;
  localparam int ACW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int BCW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int ICW = $clog2(INVULN_FRAMES + 1);

  localparam logic [AW-1:0] N = AW'(OBJECT_SIZE - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic {IDLE = 1'b0, BLINK = 1'b1} state_t;

  state_t state, state_next;

  logic [1:0]     dir_q;
  logic           moving_q;
  logic [ACW-1:0] anim_cnt;
  logic           anim_sel;
  logic [ICW-1:0] inv_cnt;
  logic [BCW-1:0] blink_cnt;
  logic           visible;

  logic [AW-1:0]  x, y, row, col;
  logic [RAW-1:0] rom_addr;
  logic           valid_q;
  logic [7:0]     pix;
  logic [7:0]     player_color;

  assign x = offsetX[AW-1:0];
  assign y = offsetY[AW-1:0];

  // Frame-rate controls are only taken at frame start so a tank never tears mid-frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dir_q    <= DIR_UP;
      moving_q <= 1'b0;
    end else if (startOfFrame) begin
      dir_q    <= direction;
      moving_q <= moving;
    end
  end

  // Tread animation: toggle the image frame every ANIM_FRAMES video frames of motion.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      anim_cnt <= '0;
      anim_sel <= 1'b0;
    end else if (startOfFrame && moving_q) begin
      if (anim_cnt == ACW'(ANIM_FRAMES - 1)) begin
        anim_cnt <= '0;
        anim_sel <= ~anim_sel;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  // Map screen offset to stored up-facing coordinates; N-v is a mirror about the centre.
  always_comb begin
    row = y;
    col = x;
    case (dir_q)
      DIR_RIGHT: begin row = N - x; col = y;     end
      DIR_DOWN:  begin row = N - y; col = N - x; end
      DIR_LEFT:  begin row = x;     col = N - y; end
      default:   begin row = y;     col = x;     end
    endcase
  end

  // Stage 1: latch ROM address and whether the pixel lies inside the bitmap.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rom_addr <= '0;
      valid_q  <= 1'b0;
    end else begin
      rom_addr <= {anim_sel, row, col};
      valid_q  <= insideRect && (offsetX < 11'(OBJECT_SIZE)) && (offsetY < 11'(OBJECT_SIZE));
    end
  end

  assign pix          = BITMAP_IMAGE[{rom_addr, 3'b000} +: 8];
  assign player_color = player_index ? P1_COLOR : P0_COLOR;

  // Stage 2: ROM read, transparency/blink masking and body recolouring.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      RGBout         <= 8'h00;
    end else if (valid_q && (pix != TRANSPARENT) && visible) begin
      drawingRequest <= 1'b1;
      RGBout         <= (pix == KEY_COLOR) ? player_color : pix;
    end else begin
      drawingRequest <= 1'b0;
      RGBout         <= TRANSPARENT;
    end
  end

  // Blink FSM: state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  // Blink FSM: a hit starts the window, the last counted frame ends it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hit) state_next = BLINK;
      BLINK:   if (startOfFrame && (inv_cnt == ICW'(1))) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Blink FSM: outputs; hits are ignored by collision logic while blinking.
  always_comb begin
    invulnerable = (state == BLINK);
  end

  // Blink datapath: frame countdown and visible/hidden half-period toggling.
  // Hits during BLINK are deliberately not reloaded; a hit coinciding with a
  // frame start in IDLE only loads, so the window is always INVULN_FRAMES long.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inv_cnt   <= '0;
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            inv_cnt   <= ICW'(INVULN_FRAMES);
            blink_cnt <= '0;
            visible   <= 1'b0;
          end
        end
        BLINK: begin
          if (startOfFrame) begin
            inv_cnt <= inv_cnt - 1'b1;
            if (blink_cnt == BCW'(BLINK_PERIOD - 1)) begin
              blink_cnt <= '0;
              visible   <= ~visible;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
            if (inv_cnt == ICW'(1)) begin
              blink_cnt <= '0;
              visible   <= 1'b1;
            end
          end
        end
        default: begin
          inv_cnt   <= '0;
          blink_cnt <= '0;
          visible   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_bitmap_animator.sv
// Directed bench for player_bitmap_animator: pipeline, rotation, recolour, animation, blink, reset.
// Image: frame 0 is 8'h11 except (r0,c0)=25 (r0,c1)=E0 (r0,c2)=FF (r0,c31)=1F (r31,c0)=1D (r31,c31)=3C.
// Frame 1 is all 8'h42 so the active tread frame is visible at offset (0,0).
module tb_player_bitmap_animator;

  localparam logic [16383:0] IMG = {
    {1024{8'h42}},
    8'h3C, {30{8'h11}}, 8'h1D,
    {960{8'h11}},
    8'h1F, {28{8'h11}}, 8'hFF, 8'hE0, 8'h25
  };

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        insideRect;
  logic [1:0]  direction;
  logic        moving;
  logic        hit;
  logic        player_index;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic        invulnerable;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  player_bitmap_animator #(.BITMAP_IMAGE(IMG)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .offsetX       (offsetX),
    .offsetY       (offsetY),
    .insideRect    (insideRect),
    .direction     (direction),
    .moving        (moving),
    .hit           (hit),
    .player_index  (player_index),
    .drawingRequest(drawingRequest),
    .RGBout        (RGBout),
    .invulnerable  (invulnerable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an offset and let it travel through both pipeline stages.
  task automatic px(input logic [10:0] ox, input logic [10:0] oy);
    offsetX = ox;
    offsetY = oy;
    tick();
    tick();
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic hit_pulse();
    hit = 1'b1;
    tick();
    hit = 1'b0;
  endtask

  // One video frame: frame start, then enough clocks for the pixel at the held offset.
  task automatic frame();
    sof();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    offsetX      = 11'd0;
    offsetY      = 11'd0;
    insideRect   = 1'b0;
    direction    = 2'd0;
    moving       = 1'b0;
    hit          = 1'b0;
    player_index = 1'b0;
    #3;
    check("reset_dr",  {31'd0, drawingRequest}, 32'd0);
    check("reset_rgb", {24'd0, RGBout},         32'h00);
    check("reset_inv", {31'd0, invulnerable},   32'd0);
    tick();
    tick();
    check("reset_held_rgb", {24'd0, RGBout}, 32'h00);
    resetN = 1'b1;

    // First pixel: exactly two clocks of latency.
    insideRect = 1'b1;
    tick();
    check("lat1_dr",  {31'd0, drawingRequest}, 32'd0);
    check("lat1_rgb", {24'd0, RGBout},         32'hFF);
    tick();
    check("lat2_dr",  {31'd0, drawingRequest}, 32'd1);
    check("lat2_rgb", {24'd0, RGBout},         32'h25);

    // Key colour recolouring and transparency.
    px(11'd1, 11'd0);
    check("key_p0_rgb", {24'd0, RGBout},         32'h1C);
    check("key_p0_dr",  {31'd0, drawingRequest}, 32'd1);
    player_index = 1'b1;
    px(11'd1, 11'd0);
    check("key_p1_rgb", {24'd0, RGBout}, 32'h5B);
    px(11'd2, 11'd0);
    check("transp_dr",  {31'd0, drawingRequest}, 32'd0);
    check("transp_rgb", {24'd0, RGBout},         32'hFF);

    // Bounds of the bitmap window.
    px(11'd40, 11'd0);
    check("x40_dr",  {31'd0, drawingRequest}, 32'd0);
    check("x40_rgb", {24'd0, RGBout},         32'hFF);
    px(11'd0, 11'd33);
    check("y33_dr", {31'd0, drawingRequest}, 32'd0);
    px(11'd31, 11'd31);
    check("corner_dr",  {31'd0, drawingRequest}, 32'd1);
    check("corner_rgb", {24'd0, RGBout},         32'h3C);

    // Rotation; direction is only taken at frame start.
    direction = 2'd2;
    px(11'd0, 11'd0);
    check("dir_midframe", {24'd0, RGBout}, 32'h25);
    sof();
    px(11'd0, 11'd0);
    check("down_00", {24'd0, RGBout}, 32'h3C);
    px(11'd31, 11'd31);
    check("down_3131", {24'd0, RGBout}, 32'h25);
    direction = 2'd1;
    sof();
    px(11'd0, 11'd0);
    check("right_00", {24'd0, RGBout}, 32'h1D);
    direction = 2'd3;
    sof();
    px(11'd0, 11'd0);
    check("left_00", {24'd0, RGBout}, 32'h1F);
    direction = 2'd0;
    sof();
    px(11'd0, 11'd0);
    check("up_00", {24'd0, RGBout}, 32'h25);

    // Animation: frame 1 samples moving, frames 2..5 count and toggle at 5, then 9, then 13.
    // moving drops before frame 13, which still counts on the previously sampled value.
    moving = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      if (i == 13) moving = 1'b0;
      sof();
      px(11'd0, 11'd0);
      check($sformatf("anim_f%0d", i), {24'd0, RGBout},
            (((i >= 5) && (i <= 8)) || (i >= 13)) ? 32'h42 : 32'h25);
    end

    // Hit: hidden for 8 frames, visible for 8, ...; second hit at frame 10 ignored.
    hit_pulse();
    check("hit_inv", {31'd0, invulnerable}, 32'd1);
    tick();
    tick();
    check("hit_hidden_dr",  {31'd0, drawingRequest}, 32'd0);
    check("hit_hidden_rgb", {24'd0, RGBout},         32'hFF);
    for (int i = 1; i <= 120; i++) begin
      frame();
      if (i == 10) hit_pulse();
      check($sformatf("blink_inv_f%0d", i), {31'd0, invulnerable}, (i < 120) ? 32'd1 : 32'd0);
      check($sformatf("blink_dr_f%0d", i), {31'd0, drawingRequest},
            (i < 120) ? (((i / 8) % 2 == 1) ? 32'd1 : 32'd0) : 32'd1);
    end
    check("after_blink_rgb", {24'd0, RGBout}, 32'h42);

    // Hit coinciding with frame start loads only; the window is still 120 frames.
    hit = 1'b1;
    startOfFrame = 1'b1;
    tick();
    hit = 1'b0;
    startOfFrame = 1'b0;
    check("hitsof_inv", {31'd0, invulnerable}, 32'd1);
    for (int i = 1; i <= 120; i++) begin
      frame();
      check($sformatf("hitsof_inv_f%0d", i), {31'd0, invulnerable}, (i < 120) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of a blink window.
    hit_pulse();
    for (int i = 1; i <= 50; i++) frame();
    check("pre_rst_inv", {31'd0, invulnerable}, 32'd1);
    #2;
    resetN = 1'b0;
    #2;
    check("midrst_dr",  {31'd0, drawingRequest}, 32'd0);
    check("midrst_rgb", {24'd0, RGBout},         32'h00);
    check("midrst_inv", {31'd0, invulnerable},   32'd0);
    tick();
    resetN = 1'b1;
    px(11'd0, 11'd0);
    check("postrst_inv", {31'd0, invulnerable},   32'd0);
    check("postrst_dr",  {31'd0, drawingRequest}, 32'd1);
    check("postrst_rgb", {24'd0, RGBout},         32'h25);

    if (fails != 0) $display("%0d comparisons did not hold", fails);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
